aes_keysched_seq: RTL and testbench
===================================

AES_KEYSCHED_SEQ -- requirements
Module: aes_keysched_seq

Interface
REQ-001 SHALL have parameter NR_MAX, default 14, meaning the maximum round count; it sizes key storage to 4*(NR_MAX+1) 32-bit words.
REQ-002 SHALL have parameter RD_REG, default 1, meaning 1 registers the read port and 0 makes it combinational.
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  request to expand key_in using mode.
REQ-006 mode  in  2  00 selects AES-128, 01 AES-192, 10 AES-256, 11 illegal.
REQ-007 key_in  in  256  cipher key; w0 = key_in[255:224], left-aligned; unused low bits ignored.
REQ-008 busy  out  1  expansion in progress.
REQ-009 key_valid  out  1  schedule complete and readable.
REQ-010 mode_err  out  1  one-cycle pulse when start arrives with mode 11.
REQ-011 num_rounds  out  4  Nr of the stored schedule: 10, 12 or 14.
REQ-012 rd_round  in  4  round index to read.
REQ-013 rd_dec  in  1  1 returns keys in decryption order.
REQ-014 round_key  out  128  words w[4r]..w[4r+3]; w[4r] is in bits [127:96].

Function
REQ-015 SHALL implement FSM IDLE -> LOAD -> EXPAND -> DONE; DONE -> LOAD on a new accepted start.
REQ-016 Start SHALL be accepted in IDLE or DONE with mode != 11; otherwise it is ignored.
REQ-017 Start with mode 11 in IDLE/DONE SHALL pulse mode_err for 1 cycle with no state change.
REQ-018 On acceptance, mode SHALL be latched, key_valid SHALL drop the next cycle, and busy SHALL rise.
REQ-019 LOAD SHALL write Nk words (4/6/8) from key_in to w[0..Nk-1] in one cycle.
REQ-020 EXPAND SHALL generate one word per cycle for i = Nk .. 4*(Nr+1)-1, i.e. 40/46/52 cycles.
REQ-021 Word generation: temp = w[i-1]; if i mod Nk == 0, temp = SubWord(RotWord(temp)) ^ Rcon[i/Nk]; else if Nk == 8 and i mod 8 == 4, temp = SubWord(temp); w[i] = w[i-Nk] ^ temp.
REQ-022 Rcon SHALL be {01,02,04,08,10,20,40,80,1B,36} in the top byte.
REQ-023 key_valid SHALL assert exactly 1+40/46/52 = 41/47/53 cycles after the start-acceptance edge; busy SHALL fall on the same edge.
REQ-024 Start during LOAD/EXPAND SHALL be ignored, and the current expansion SHALL complete unaffected.
REQ-025 Read index SHALL be r = rd_round when rd_dec = 0, and Nr - rd_round when rd_dec = 1.
REQ-026 round_key SHALL be valid one cycle after rd_round/rd_dec when RD_REG = 1, and in the same cycle when RD_REG = 0.
REQ-027 If rd_round > Nr or key_valid = 0, round_key SHALL be all-zero.
REQ-028 num_rounds SHALL reflect the latched mode and update at acceptance.

Reset
REQ-029 Reset SHALL force IDLE, busy = 0, key_valid = 0, mode_err = 0, num_rounds = 10 and round_key = 0, all immediately and asynchronously.
REQ-030 Reset mid-EXPAND SHALL abandon the schedule; key_valid SHALL stay 0 until a full new expansion completes.
REQ-031 Key storage need not be cleared by reset; REQ-027 masks it.

Structure
REQ-032 aes_pkg SHALL hold the mode enum, FSM state typedef, Nk/Nr lookup functions and the Rcon table.
REQ-033 A single sub-module aes_subword SHALL provide four aes_sbox instances (32-bit SubWord); it is shared for both SubWord cases.
REQ-034 Word storage SHALL be a flop array indexed by a word counter; no per-round unrolled instances.

Verification
REQ-035 AES-128: key 2b7e1516 28aed2a6 abf71588 09cf4f3c -> key_valid at +41 cycles; round 10 = d014f9a8 c9ee2589 e13f0cc8 b6630ca6; rd_dec = 1, rd_round = 0 returns the same value.
REQ-036 AES-192: key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b -> key_valid at +47; round 12 = e98ba06f 448c773c 8ecc7204 01002202; num_rounds = 12.
REQ-037 AES-256: key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4 -> key_valid at +53; round 1 = 1f352c07 3b6108d7 2d9810a3 0914dff4; round 14 = fe4890d1 e6188d0b 046df344 706c631e.
REQ-038 Start with mode 11 -> mode_err pulses 1 cycle, busy stays 0, prior key_valid and schedule are retained.
REQ-039 Start pulsed again at cycle 20 of expansion -> ignored, key_valid still at +41; reset asserted at cycle 20 -> key_valid = 0 and round_key = 0 until a restarted expansion finishes.
REQ-040 After a valid 128-bit schedule, rd_round = 11 -> round_key = 0; back-to-back 256-bit start from DONE -> key_valid drops the next cycle.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types and lookups: key-size mode, FSM states,
// Nk/Nr per mode and the round-constant table.
package aes_pkg;

  typedef enum logic [1:0] {
    MODE_128 = 2'b00,
    MODE_192 = 2'b01,
    MODE_256 = 2'b10,
    MODE_ILL = 2'b11
  } aes_mode_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_LOAD   = 2'b01,
    S_EXPAND = 2'b10,
    S_DONE   = 2'b11
  } ks_state_e;

  function automatic logic [3:0] nk_of(input aes_mode_e m);
    case (m)
      MODE_192: nk_of = 4'd6;
      MODE_256: nk_of = 4'd8;
      default:  nk_of = 4'd4;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(input aes_mode_e m);
    case (m)
      MODE_192: nr_of = 4'd12;
      MODE_256: nr_of = 4'd14;
      default:  nr_of = 4'd10;
    endcase
  endfunction

  // Rcon[j] for j = 1..10; only the top byte is non-zero
  function automatic logic [7:0] rcon_of(input logic [3:0] j);
    case (j)
      4'd1:    rcon_of = 8'h01;
      4'd2:    rcon_of = 8'h02;
      4'd3:    rcon_of = 8'h04;
      4'd4:    rcon_of = 8'h08;
      4'd5:    rcon_of = 8'h10;
      4'd6:    rcon_of = 8'h20;
      4'd7:    rcon_of = 8'h40;
      4'd8:    rcon_of = 8'h80;
      4'd9:    rcon_of = 8'h1b;
      4'd10:   rcon_of = 8'h36;
      default: rcon_of = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/aes_subword.sv
// 32-bit SubWord built from four byte S-boxes. The S-box is computed as the
// GF(2^8) inverse (x^254) followed by the AES affine transform.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252, inv;

  // x^254 == x^-1 in GF(2^8), and maps 0 to 0 as the S-box needs
  always_comb begin
    x2   = gf_mul(din, din);
    x3   = gf_mul(x2, din);
    x6   = gf_mul(x3, x3);
    x12  = gf_mul(x6, x6);
    x15  = gf_mul(x12, x3);
    x30  = gf_mul(x15, x15);
    x60  = gf_mul(x30, x30);
    x120 = gf_mul(x60, x60);
    x240 = gf_mul(x120, x120);
    x252 = gf_mul(x240, x12);
    inv  = gf_mul(x252, x2);
    dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  end

endmodule

module aes_subword (
  input  logic [31:0] din,
  output logic [31:0] dout
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (din[8*g +: 8]),
      .dout (dout[8*g +: 8])
    );
  end

endmodule

// File: rtl/aes_keysched_seq.sv
// Sequential AES key expansion (128/192/256): loads Nk key words, then
// derives one schedule word per cycle into a flop array read per round.
module aes_keysched_seq
  import aes_pkg::*;
#(
  parameter int NR_MAX = 14,
  parameter int RD_REG = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         busy,
  output logic         key_valid,
  output logic         mode_err,
  output logic [3:0]   num_rounds,
  input  logic [3:0]   rd_round,
  input  logic         rd_dec,
  output logic [127:0] round_key
);

  localparam int NWORDS = 4 * (NR_MAX + 1);
  localparam int WIDX   = $clog2(NWORDS);

  ks_state_e       state_q, state_d;
  aes_mode_e       mode_q;
  logic [3:0]      nr_q;
  logic [WIDX-1:0] cnt_q;
  logic [2:0]      kcnt_q;   // i mod Nk
  logic [3:0]      rnd_q;    // i / Nk, indexes Rcon
  logic            mode_err_q;
  logic            accept, bad_mode;

  logic [31:0]     w [NWORDS];

  logic [WIDX-1:0] nk, last_idx;
  logic [31:0]     w_prev, w_back, sub_in, sub_out, temp, w_new;

  assign nk       = WIDX'(nk_of(mode_q));
  assign last_idx = WIDX'({nr_q, 2'b00}) + WIDX'(3);

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    bad_mode = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          if (aes_mode_e'(mode) == MODE_ILL) begin
            bad_mode = 1'b1;
          end else begin
            accept  = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_LOAD:   state_d = S_EXPAND;
      S_EXPAND: if (cnt_q == last_idx) state_d = S_DONE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      mode_q     <= MODE_128;
      nr_q       <= 4'd10;
      cnt_q      <= '0;
      kcnt_q     <= '0;
      rnd_q      <= '0;
      mode_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mode_err_q <= bad_mode;
      if (accept) begin
        mode_q <= aes_mode_e'(mode);
        nr_q   <= nr_of(aes_mode_e'(mode));
      end
      if (state_q == S_LOAD) begin
        cnt_q  <= nk;
        kcnt_q <= '0;
        rnd_q  <= 4'd1;
      end else if (state_q == S_EXPAND) begin
        cnt_q <= cnt_q + WIDX'(1);
        if ({1'b0, kcnt_q} == nk_of(mode_q) - 4'd1) begin
          kcnt_q <= '0;
          rnd_q  <= rnd_q + 4'd1;
        end else begin
          kcnt_q <= kcnt_q + 3'd1;
        end
      end
    end
  end

  // Word generator; one shared SubWord serves both the RotWord and Nk=8 cases
  assign w_prev = w[cnt_q - WIDX'(1)];
  assign w_back = w[cnt_q - nk];
  assign sub_in = (kcnt_q == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  aes_subword u_subword (
    .din  (sub_in),
    .dout (sub_out)
  );

  always_comb begin
    temp = w_prev;
    if (kcnt_q == 3'd0)
      temp = sub_out ^ {rcon_of(rnd_q), 24'h000000};
    else if (mode_q == MODE_256 && kcnt_q == 3'd4)
      temp = sub_out;
  end

  assign w_new = w_back ^ temp;

  // Storage carries no reset; key_valid masks stale contents on the read side
  always_ff @(posedge clk) begin
    if (state_q == S_LOAD) begin
      for (int j = 0; j < 8; j++)
        if (j < int'(nk_of(mode_q))) w[j] <= key_in[255-32*j -: 32];
    end else if (state_q == S_EXPAND) begin
      w[cnt_q] <= w_new;
    end
  end

  assign busy       = (state_q == S_LOAD) || (state_q == S_EXPAND);
  assign key_valid  = (state_q == S_DONE);
  assign mode_err   = mode_err_q;
  assign num_rounds = nr_q;

  logic [3:0]      r_eff;
  logic [WIDX-1:0] base;
  logic [127:0]    rk_comb;

  assign r_eff = rd_dec ? (nr_q - rd_round) : rd_round;
  assign base  = WIDX'({r_eff, 2'b00});

  always_comb begin
    rk_comb = '0;
    if (key_valid && rd_round <= nr_q)
      rk_comb = {w[base], w[base + WIDX'(1)], w[base + WIDX'(2)], w[base + WIDX'(3)]};
  end

  if (RD_REG != 0) begin : g_rd_reg
    logic [127:0] rk_q;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) rk_q <= '0;
      else       rk_q <= rk_comb;
    end
    assign round_key = rk_q;
  end else begin : g_rd_comb
    assign round_key = rk_comb;
  end

endmodule

// File: tb/tb_aes_keysched_seq.sv
// Directed bench for aes_keysched_seq using FIPS-197 key-expansion vectors.
module tb_aes_keysched_seq;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [1:0]   mode;
  logic [255:0] key_in;
  logic         busy, key_valid, mode_err;
  logic [3:0]   num_rounds;
  logic [3:0]   rd_round;
  logic         rd_dec;
  logic [127:0] round_key;

  int checks = 0;
  int errors = 0;
  int n;

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_keysched_seq #(.NR_MAX(14), .RD_REG(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .key_in     (key_in),
    .busy       (busy),
    .key_valid  (key_valid),
    .mode_err   (mode_err),
    .num_rounds (num_rounds),
    .rd_round   (rd_round),
    .rd_dec     (rd_dec),
    .round_key  (round_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge; returns at acceptance edge + 1
  task automatic pulse_start(input logic [1:0] m, input logic [255:0] k);
    @(negedge clk);
    start  = 1'b1;
    mode   = m;
    key_in = k;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count edges until key_valid; optionally re-pulse start at cycle poke_at
  task automatic wait_valid(output int cyc, input int poke_at);
    cyc = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1 start = 1'b0;
      cyc = i;
      if (key_valid) break;
      if (i == poke_at) begin
        start = 1'b1;
        mode  = 2'b10;
      end
    end
  endtask

  task automatic read_rk(input logic [3:0] r, input logic d);
    @(negedge clk);
    rd_round = r;
    rd_dec   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; mode = 2'b00; key_in = '0; rd_round = 4'd0; rd_dec = 1'b0;
    #12;
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_kv", 128'(key_valid), 128'd0);
    chk("rst_merr", 128'(mode_err), 128'd0);
    chk("rst_nr", 128'(num_rounds), 128'd10);
    chk("rst_rk", round_key, 128'd0);
    @(negedge clk) reset = 1'b0;

    // AES-128
    pulse_start(2'b00, K128);
    chk("a128_busy_up", 128'(busy), 128'd1);
    wait_valid(n, 0);
    chk("a128_latency", 128'(n), 128'd41);
    chk("a128_busy_dn", 128'(busy), 128'd0);
    chk("a128_nr", 128'(num_rounds), 128'd10);
    read_rk(4'd10, 1'b0);
    chk("a128_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd0, 1'b1);
    chk("a128_dec0", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    read_rk(4'd0, 1'b0);
    chk("a128_r0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    read_rk(4'd11, 1'b0);
    chk("a128_r11_zero", round_key, 128'd0);

    // Illegal mode from DONE
    rd_round = 4'd10; rd_dec = 1'b0;
    pulse_start(2'b11, K256);
    chk("ill_merr", 128'(mode_err), 128'd1);
    chk("ill_busy", 128'(busy), 128'd0);
    chk("ill_kv", 128'(key_valid), 128'd1);
    @(posedge clk); #1;
    chk("ill_merr_drop", 128'(mode_err), 128'd0);
    chk("ill_r10_kept", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Start during expansion is ignored
    pulse_start(2'b00, K128);
    chk("rst_kv_drop", 128'(key_valid), 128'd0);
    wait_valid(n, 20);
    chk("poke_latency", 128'(n), 128'd41);
    chk("poke_nr", 128'(num_rounds), 128'd10);
    read_rk(4'd10, 1'b0);
    chk("poke_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // Reset mid-expansion
    pulse_start(2'b00, K128);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("mid_rst_kv", 128'(key_valid), 128'd0);
    chk("mid_rst_busy", 128'(busy), 128'd0);
    chk("mid_rst_rk", round_key, 128'd0);
    @(negedge clk) reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk("post_rst_kv", 128'(key_valid), 128'd0);
    pulse_start(2'b00, K128);
    repeat (10) @(posedge clk);
    #1;
    chk("restart_kv", 128'(key_valid), 128'd0);
    chk("restart_rk", round_key, 128'd0);
    wait_valid(n, 0);
    chk("restart_latency", 128'(n), 128'd31);
    read_rk(4'd10, 1'b0);
    chk("restart_r10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    // AES-192
    pulse_start(2'b01, K192);
    chk("a192_nr_acc", 128'(num_rounds), 128'd12);
    wait_valid(n, 0);
    chk("a192_latency", 128'(n), 128'd47);
    read_rk(4'd12, 1'b0);
    chk("a192_r12", round_key, 128'he98ba06f448c773c8ecc720401002202);
    read_rk(4'd0, 1'b0);
    chk("a192_r0", round_key, 128'h8e73b0f7da0e6452c810f32b809079e5);
    read_rk(4'd13, 1'b0);
    chk("a192_r13_zero", round_key, 128'd0);

    // Back-to-back AES-256 from DONE
    pulse_start(2'b10, K256);
    chk("a256_kv_drop", 128'(key_valid), 128'd0);
    chk("a256_busy", 128'(busy), 128'd1);
    chk("a256_nr", 128'(num_rounds), 128'd14);
    wait_valid(n, 0);
    chk("a256_latency", 128'(n), 128'd53);
    read_rk(4'd1, 1'b0);
    chk("a256_r1", round_key, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk(4'd14, 1'b0);
    chk("a256_r14", round_key, 128'hfe4890d1e6188d0b046df344706c631e);
    read_rk(4'd13, 1'b1);
    chk("a256_dec13", round_key, 128'h1f352c073b6108d72d9810a30914dff4);
    read_rk(4'd14, 1'b1);
    chk("a256_dec14", round_key, 128'h603deb1015ca71be2b73aef0857d7781);

    // Async reset returns num_rounds to 10 immediately
    #2 reset = 1'b1;
    #1;
    chk("final_rst_nr", 128'(num_rounds), 128'd10);
    chk("final_rst_kv", 128'(key_valid), 128'd0);
    chk("final_rst_rk", round_key, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
